// File: rtl/riscv_mem_pkg.sv
// Shared types and default address map for the memory-side bus responder.
//   state_e  : responder FSM encoding (IDLE, WAIT, RESP)
//   region_e : decoded address region (text, data RAM, GPIO, unmapped)
//   DEF_*    : default base addresses used as parameter defaults
package riscv_mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      REG_TEXT = 2'd0,
      REG_DATA = 2'd1,
      REG_GPIO = 2'd2,
      REG_NONE = 2'd3
   } region_e;

   localparam logic [31:0] DEF_TEXT_BASE = 32'h0040_0000;
   localparam logic [31:0] DEF_DATA_BASE = 32'h1001_0000;
   localparam logic [31:0] DEF_GPIO_ADDR = 32'h1001_0400;

endpackage

// File: rtl/mem_region_decode.sv
// Combinational address decoder for the memory bus responder.
//   addr   in   byte address to decode
//   rd, wr in   request type
//   region out  decoded region
//   idx    out  word index within the region, (addr - base) >> 2
//   err    out  request must be answered with an error
module mem_region_decode
   import riscv_mem_pkg::*;
#(
   parameter logic [31:0] TEXT_BASE  = DEF_TEXT_BASE,
   parameter int unsigned TEXT_WORDS = 256,
   parameter logic [31:0] DATA_BASE  = DEF_DATA_BASE,
   parameter int unsigned DATA_WORDS = 256,
   parameter logic [31:0] GPIO_ADDR  = DEF_GPIO_ADDR,
   parameter int unsigned IDX_W      = 8
) (
   input  logic [31:0]      addr,
   input  logic             rd,
   input  logic             wr,
   output region_e          region,
   output logic [IDX_W-1:0] idx,
   output logic             err
);

   // 33-bit compares so a region ending at the top of the address space cannot wrap.
   logic [32:0] a33;
   logic        in_text;
   logic        in_data;

   always_comb begin
      a33     = {1'b0, addr};
      in_text = (a33 >= {1'b0, TEXT_BASE}) &&
                (a33 <  ({1'b0, TEXT_BASE} + 33'(TEXT_WORDS) * 33'd4));
      in_data = (a33 >= {1'b0, DATA_BASE}) &&
                (a33 <  ({1'b0, DATA_BASE} + 33'(DATA_WORDS) * 33'd4));
      region  = REG_NONE;
      idx     = '0;
      if (addr == GPIO_ADDR) begin
         region = REG_GPIO;
      end else if (in_text) begin
         region = REG_TEXT;
         idx    = IDX_W'((addr - TEXT_BASE) >> 2);
      end else if (in_data) begin
         region = REG_DATA;
         idx    = IDX_W'((addr - DATA_BASE) >> 2);
      end
      err = (rd && wr) || (addr[1:0] != 2'b00) || (region == REG_NONE) ||
            ((region == REG_TEXT) && wr);
   end

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-side responder for the multicycle RISC-V controller.
//   clk, rst                  clock; synchronous active-high reset
//   MemRead, MemWrite         request from controller (held until Ready)
//   Addr, WriteData           request address and store data
//   ReadData, Ready, Err      response; Ready/Err are one-cycle pulses
//   GpioOut                   GPIO output register
//   TextLoad/Addr/Data        text preload port, honoured only while rst=1
module mem_bus_responder
   import riscv_mem_pkg::*;
#(
   parameter logic [31:0] TEXT_BASE   = DEF_TEXT_BASE,
   parameter int unsigned TEXT_WORDS  = 256,
   parameter logic [31:0] DATA_BASE   = DEF_DATA_BASE,
   parameter int unsigned DATA_WORDS  = 256,
   parameter logic [31:0] GPIO_ADDR   = DEF_GPIO_ADDR,
   parameter int unsigned WAIT_STATES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [31:0] Addr,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        Ready,
   output logic        Err,
   output logic [31:0] GpioOut,
   input  logic        TextLoad,
   input  logic [7:0]  TextLoadAddr,
   input  logic [31:0] TextLoadData
);

   localparam int unsigned TW    = $clog2(TEXT_WORDS);
   localparam int unsigned DW    = $clog2(DATA_WORDS);
   localparam int unsigned IDX_W = (TW > DW) ? TW : DW;
   localparam logic [3:0]  WS    = 4'(WAIT_STATES);

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, wdata_q;
   logic        rd_q, wr_q;
   logic        ready_q, err_q;
   logic [31:0] rdata_q, gpio_q;

   logic [31:0] text_mem [TEXT_WORDS];
   logic [31:0] data_mem [DATA_WORDS];

   logic             req;
   logic             enter_resp;
   logic             commit;
   logic [31:0]      dec_addr;
   logic             dec_rd, dec_wr;
   region_e          dec_region;
   logic [IDX_W-1:0] dec_idx;
   logic             dec_err;
   logic [31:0]      read_word;

   assign req = MemRead || MemWrite;

   // In IDLE decode the live request so WAIT_STATES=0 can respond straight away;
   // afterwards decode the latched copy so mid-request Addr changes are ignored.
   assign dec_addr = (state_q == IDLE) ? Addr     : addr_q;
   assign dec_rd   = (state_q == IDLE) ? MemRead  : rd_q;
   assign dec_wr   = (state_q == IDLE) ? MemWrite : wr_q;

   mem_region_decode #(
      .TEXT_BASE  (TEXT_BASE),
      .TEXT_WORDS (TEXT_WORDS),
      .DATA_BASE  (DATA_BASE),
      .DATA_WORDS (DATA_WORDS),
      .GPIO_ADDR  (GPIO_ADDR),
      .IDX_W      (IDX_W)
   ) u_decode (
      .addr   (dec_addr),
      .rd     (dec_rd),
      .wr     (dec_wr),
      .region (dec_region),
      .idx    (dec_idx),
      .err    (dec_err)
   );

   always_comb begin
      read_word = '0;
      case (dec_region)
         REG_TEXT: read_word = text_mem[dec_idx[TW-1:0]];
         REG_DATA: read_word = data_mem[dec_idx[DW-1:0]];
         REG_GPIO: read_word = gpio_q;
         default:  read_word = '0;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      enter_resp = 1'b0;
      case (state_q)
         IDLE: begin
            if (req) begin
               cnt_d = '0;
               if (WAIT_STATES == 0) begin
                  state_d    = RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (!req) begin
               state_d = IDLE;  // requester withdrew: abort silently
            end else begin
               cnt_d = cnt_q + 4'd1;
               if (cnt_d == WS) begin
                  state_d    = RESP;
                  enter_resp = 1'b1;
               end
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Writes land at the edge that ends RESP; in RESP the decoder sees the latched request.
   assign commit = (state_q == RESP) && wr_q && !dec_err;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
         gpio_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if ((state_q == IDLE) && req) begin
            addr_q  <= Addr;
            wdata_q <= WriteData;
            rd_q    <= MemRead;
            wr_q    <= MemWrite;
         end
         ready_q <= enter_resp;
         err_q   <= enter_resp && dec_err;
         rdata_q <= (enter_resp && dec_rd && !dec_err) ? read_word : 32'h0;
         if (commit && (dec_region == REG_GPIO)) begin
            gpio_q <= wdata_q;
         end
      end
   end

   // Arrays carry no reset; text is only loadable during reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         if (TextLoad) begin
            text_mem[TW'(TextLoadAddr)] <= TextLoadData;
         end
      end else if (commit && (dec_region == REG_DATA)) begin
         data_mem[dec_idx[DW-1:0]] <= wdata_q;
      end
   end

   assign ReadData = rdata_q;
   assign Ready    = ready_q;
   assign Err      = err_q;
   assign GpioOut  = gpio_q;

endmodule

// File: doc/mem_bus_responder.md
Name: mem_bus_responder

Overview:
- Memory-side responder for the multicycle RISC-V control unit.
- Services the unified instruction/data memory requests the controller issues: read requests during instruction fetch and load, write requests during store.
- Decodes the address into three regions: text (read-only), data RAM (read/write) and one GPIO output register.
- Applies a programmable number of wait states, then returns read data with a one-cycle Ready pulse, or flags an error.

Parameters:
- TEXT_BASE, 32'h0040_0000, base byte address of text region
- TEXT_WORDS, 256, text region depth in 32-bit words
- DATA_BASE, 32'h1001_0000, base byte address of data RAM
- DATA_WORDS, 256, data RAM depth in 32-bit words
- GPIO_ADDR, 32'h1001_0400, byte address of GPIO output register; must lie outside the data range
- WAIT_STATES, 1, idle cycles between request acceptance and Ready; legal range 0..15

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- MemRead  in  1  read request from controller
- MemWrite  in  1  write request from controller
- Addr  in  32  byte address; word-aligned accesses only
- WriteData  in  32  store data
- ReadData  out  32  read data; valid only while Ready=1
- Ready  out  1  one-cycle completion pulse
- Err  out  1  one-cycle error pulse, coincident with Ready
- GpioOut  out  32  GPIO output register
- TextLoad  in  1  side-band text preload enable; only legal while rst=1
- TextLoadAddr  in  8  text word index for preload
- TextLoadData  in  32  preload data

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, wait counter=0, Ready=0, Err=0, ReadData=0, GpioOut=0.
  - Text and data arrays are not cleared.
  - While rst=1 and TextLoad=1, text[TextLoadAddr] is written with TextLoadData.
- State IDLE:
  - If MemRead or MemWrite is high, latch Addr/WriteData and the request type.
  - Decode region and check errors, then go to WAIT (WAIT_STATES>0) or RESP (WAIT_STATES=0).
- State WAIT:
  - Counter counts 1..WAIT_STATES, then go to RESP.
  - If both MemRead and MemWrite go low: abort, return to IDLE, no side effects, no Ready.
- State RESP:
  - Ready=1 for exactly one cycle, then return to IDLE.
  - A read drives ReadData from the latched address.
  - A write commits to its target at the clk edge ending RESP.
- Latency: a request first seen at edge N gives Ready in cycle N+1+WAIT_STATES.
- Back-to-back: a new request is accepted only in IDLE; minimum request spacing is WAIT_STATES+2 cycles.
- Requester protocol: hold Addr, WriteData and the request bits stable until Ready. Changes to Addr mid-request are ignored because the values are latched.
- Error conditions. Each sets Err=1 with Ready, ReadData=0 and no write:
  - MemRead and MemWrite both high at acceptance
  - Addr[1:0] != 0
  - address outside the text, data and GPIO regions
  - write to the text region
- Region index = (Addr - base) >> 2. The region check is an unsigned compare against base + 4*WORDS, with no wrap at 32'hFFFF_FFFF.
- GPIO: a read returns the current GpioOut; a write updates GpioOut at the end of RESP.
- Reads are combinational from the latched index into the arrays, registered into ReadData on entry to RESP.
- Reset mid-operation: the transaction is dropped, no write commits, and Ready/Err stay 0.

Decomposition:
- Shared package (riscv_mem_pkg):
  - state encoding: IDLE=2'd0, WAIT=2'd1, RESP=2'd2
  - region encoding: REG_TEXT, REG_DATA, REG_GPIO, REG_NONE
  - default base-address constants
- One sub-module, mem_region_decode:
  - combinational region, word index and error flags from Addr, request type and parameters.
- The FSM, counter and arrays stay in mem_bus_responder.

Test Plan:
- Preload text[0]=32'h0000_0513; WAIT_STATES=1; MemRead with Addr=32'h0040_0000 -> Ready 2 cycles after acceptance, ReadData=32'h0000_0513, Err=0.
- Write 32'hDEAD_BEEF to 32'h1001_0008, then read the same address -> write Ready with Err=0, read returns 32'hDEAD_BEEF.
- Write 32'h0000_00A5 to GPIO_ADDR -> GpioOut=32'h0000_00A5 after RESP; read back returns 32'h0000_00A5.
- Error cases, each -> Err=1 with Ready and ReadData=0:
  - MemWrite to 32'h0040_0004: text[1] unchanged.
  - MemRead at 32'h1001_0002: misaligned.
  - MemRead at 32'h2000_0000: unmapped.
  - MemRead and MemWrite both high.
- WAIT_STATES=3:
  - Drop MemRead in the 2nd wait cycle -> no Ready, back in IDLE.
  - Repeat with MemWrite to 32'h1001_0010 -> RAM word unchanged.
- Assert rst during WAIT of a write to 32'h1001_000C -> Ready=0, GpioOut=0, RAM word unchanged, next request served normally.
